// File: rtl/trail_block_reader.sv
// ---------------------------------------------------------------------------
// trail_block_reader
//
// Checks one BLK_W x BLK_H cell of the trail frame-buffer RAM on request.
// It reports whether the cell leaves the arena and whether any pixel in it is
// already owned. When a pixel is owned, it also reports the owner code of the
// first owned pixel in raster order. Player movement logic calls it on demand
// instead of sampling collisions against the raster.
//
// Ports
//   CLOCK_50   in   system clock, all logic on rising edge
//   reset      in   synchronous, active-high
//   req_valid  in   check request
//   req_ready  out  high only while idle; accept = req_valid & req_ready
//   req_x      in   [9:0]  cell top-left x (pixels)
//   req_y      in   [9:0]  cell top-left y (pixels)
//   rd_en      out  RAM read strobe
//   rd_addr    out  [18:0] RAM read address (x + y*H_RES)
//   rd_data    in   [7:0]  RAM read data, valid RD_LAT edges after rd_en
//   rsp_valid  out  one-cycle result pulse
//   rsp_hit    out  cell contains a nonzero byte
//   rsp_oob    out  cell extends outside the arena
//   rsp_owner  out  [7:0]  first nonzero byte in raster order, 0 if none
// ---------------------------------------------------------------------------
module trail_block_reader #(
  parameter int H_RES      = 640,
  parameter int BLK_W      = 8,
  parameter int BLK_H      = 8,
  parameter int ARENA_XMIN = 16,
  parameter int ARENA_XMAX = 623,
  parameter int ARENA_YMIN = 16,
  parameter int ARENA_YMAX = 463,
  parameter int RD_LAT     = 1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_x,
  input  logic [9:0]  req_y,
  output logic        rd_en,
  output logic [18:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        rsp_valid,
  output logic        rsp_hit,
  output logic        rsp_oob,
  output logic [7:0]  rsp_owner
);

  localparam int COL_W = (BLK_W  > 1) ? $clog2(BLK_W)  : 1;
  localparam int ROW_W = (BLK_H  > 1) ? $clog2(BLK_H)  : 1;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(BLK_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BLK_H - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

  localparam logic [10:0] X_MIN = 11'(ARENA_XMIN);
  localparam logic [10:0] X_MAX = 11'(ARENA_XMAX);
  localparam logic [10:0] Y_MIN = 11'(ARENA_YMIN);
  localparam logic [10:0] Y_MAX = 11'(ARENA_YMAX);
  localparam logic [10:0] W_M1  = 11'(BLK_W - 1);
  localparam logic [10:0] H_M1  = 11'(BLK_H - 1);

  localparam logic [18:0] LINE     = 19'(H_RES);
  // Jump from the last pixel of one cell row to the first pixel of the next.
  localparam logic [18:0] ROW_STEP = 19'(H_RES - BLK_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [9:0]        x_q, y_q;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [LAT_W-1:0]  lat_cnt;
  logic [RD_LAT-1:0] rd_vld;

  logic        accept;
  logic        cell_oob;
  logic        last_read;
  logic        drain_done;
  logic [18:0] base;
  logic [10:0] x_lo, x_hi, y_lo, y_hi;

  // The bounds are widened to 11 bits so that x+BLK_W-1 cannot wrap past 1023.
  always_comb begin
    x_lo     = {1'b0, x_q};
    y_lo     = {1'b0, y_q};
    x_hi     = x_lo + W_M1;
    y_hi     = y_lo + H_M1;
    cell_oob = (x_lo < X_MIN) || (x_hi > X_MAX) ||
               (y_lo < Y_MIN) || (y_hi > Y_MAX);
    base     = 19'(x_q) + (19'(y_q) * LINE);
  end

  assign accept     = req_valid && req_ready;
  assign last_read  = (col == COL_LAST) && (row == ROW_LAST);
  assign drain_done = (lat_cnt == LAT_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rd_en      = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = S_CHECK;
      end
      S_CHECK: begin
        state_next = cell_oob ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        rd_en = 1'b1;
        if (last_read) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_done) state_next = S_DONE;
      end
      S_DONE: begin
        rsp_valid  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Marks which cycles carry real read data. RAM output is ignored in all
  // other cycles, whatever value it shows.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rd_vld <= '0;
    end else begin
      rd_vld[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) rd_vld[i] <= rd_vld[i-1];
    end
  end

  // Holds the request, walks the cell addresses, and counts the drain.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      rd_addr <= '0;
      col     <= '0;
      row     <= '0;
      lat_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            x_q <= req_x;
            y_q <= req_y;
          end
        end
        S_CHECK: begin
          col     <= '0;
          row     <= '0;
          lat_cnt <= '0;
          if (!cell_oob) rd_addr <= base;
        end
        S_ISSUE: begin
          if (!last_read) begin
            if (col == COL_LAST) begin
              col     <= '0;
              row     <= row + ROW_W'(1);
              rd_addr <= rd_addr + ROW_STEP;
            end else begin
              col     <= col + COL_W'(1);
              rd_addr <= rd_addr + 19'd1;
            end
          end
        end
        S_DRAIN: begin
          lat_cnt <= lat_cnt + LAT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers. The first nonzero byte wins the owner field, and later
  // hits only keep rsp_hit set. An accept clears the previous result. The
  // clear comes last so that it takes priority.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rsp_hit   <= 1'b0;
      rsp_oob   <= 1'b0;
      rsp_owner <= '0;
    end else begin
      if (rd_vld[RD_LAT-1] && (rd_data != 8'h00)) begin
        rsp_hit <= 1'b1;
        if (!rsp_hit) rsp_owner <= rd_data;
      end
      if ((state == S_CHECK) && cell_oob) rsp_oob <= 1'b1;
      if (accept) begin
        rsp_hit   <= 1'b0;
        rsp_oob   <= 1'b0;
        rsp_owner <= '0;
      end
    end
  end

endmodule

// File: tb/tb_trail_block_reader.sv
// ---------------------------------------------------------------------------
// tb_trail_block_reader
//
// Directed bench for trail_block_reader. A sparse RAM model answers reads.
// The bench pushes the expected read addresses and responses into queues
// when it drives a request. A negedge monitor pops the addresses as rd_en
// strobes. The main sequence pops each response when rsp_valid pulses.
// ---------------------------------------------------------------------------
module tb_trail_block_reader;

  localparam int RD_LAT   = 1;
  localparam int BLK      = 64;
  localparam int SCAN_LAT = BLK + RD_LAT + 1;

  typedef struct {
    logic       hit;
    logic       oob;
    logic [7:0] owner;
    int         lat;
  } exp_t;

  logic        CLOCK_50;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_x;
  logic [9:0]  req_y;
  logic        rd_en;
  logic [18:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rsp_valid;
  logic        rsp_hit;
  logic        rsp_oob;
  logic [7:0]  rsp_owner;

  int checks = 0;
  int errors = 0;

  logic [7:0]        mem [int];
  logic [7:0]        stray_val = 8'h00;
  logic [RD_LAT-1:0] pipe_v = '0;
  logic [7:0]        pipe_d [RD_LAT];

  logic [18:0] addr_q [$];
  exp_t        rsp_q  [$];

  trail_block_reader #(.RD_LAT(RD_LAT)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rsp_valid (rsp_valid),
    .rsp_hit   (rsp_hit),
    .rsp_oob   (rsp_oob),
    .rsp_owner (rsp_owner)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [7:0] ramRead(input int a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // RAM with RD_LAT cycles of latency. Outside valid slots it shows stray_val.
  always @(posedge CLOCK_50) begin
    pipe_v[0] <= rd_en;
    pipe_d[0] <= rd_en ? ramRead(int'(rd_addr)) : 8'h00;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end
  assign rd_data = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : stray_val;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read-address scoreboard
  always @(negedge CLOCK_50) begin
    if (rd_en) begin
      checks++;
      assert (addr_q.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_rd_en observed addr=%0d expected no read", rd_addr);
      end
      if (addr_q.size() != 0) begin
        logic [18:0] ea;
        ea = addr_q.pop_front();
        checks++;
        assert (rd_addr === ea) else begin
          errors++;
          $error("[TB] FAIL rd_addr observed=%0d expected=%0d", rd_addr, ea);
        end
      end
    end
  end

  // Model of one request: arena test, raster read list, first-owner scan.
  task automatic pushExpect(input int x, input int y);
    exp_t e;
    e.oob   = (x < 16) || (x + 7 > 623) || (y < 16) || (y + 7 > 463);
    e.hit   = 1'b0;
    e.owner = 8'h00;
    e.lat   = e.oob ? 1 : SCAN_LAT;
    if (!e.oob) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          int a;
          logic [7:0] v;
          a = (x + c) + (y + r) * 640;
          addr_q.push_back(19'(a));
          v = ramRead(a);
          if ((v != 8'h00) && !e.hit) begin
            e.hit   = 1'b1;
            e.owner = v;
          end
        end
      end
    end
    rsp_q.push_back(e);
  endtask

  // Presents a request, lets it be accepted, and returns 1 after the accept edge.
  task automatic applyStimulus(input int x, input int y, input bit hold);
    pushExpect(x, y);
    @(negedge CLOCK_50);
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_x     = 10'(x);
    req_y     = 10'(y);
    req_valid = 1'b1;
    @(posedge CLOCK_50);
    #1;
    if (!hold) req_valid = 1'b0;
    checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
    checkOutput("rsp_cleared_on_accept", 32'({rsp_hit, rsp_oob, rsp_owner}), 32'd0);
  endtask

  // Counts edges from the accept edge until rsp_valid, then checks the result.
  task automatic waitResponse(input int left);
    exp_t e;
    int   n;
    bit   seen;
    seen = 1'b0;
    for (n = 1; n <= 300; n++) begin
      @(posedge CLOCK_50);
      #1;
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("rsp_valid_seen", 32'(seen), 32'd1);
    e = rsp_q.pop_front();
    if (seen) begin
      checkOutput("rsp_latency", 32'(n), 32'(e.lat));
      checkOutput("rsp_hit", 32'(rsp_hit), 32'(e.hit));
      checkOutput("rsp_oob", 32'(rsp_oob), 32'(e.oob));
      checkOutput("rsp_owner", 32'(rsp_owner), 32'(e.owner));
      checkOutput("reads_left", 32'(addr_q.size()), 32'(left));
      checkOutput("req_ready_in_done", 32'(req_ready), 32'd0);
      @(posedge CLOCK_50);
      #1;
      checkOutput("rsp_valid_pulse", 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    bit got;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_x     = '0;
    req_y     = '0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    checkOutput("reset_rd_en", 32'(rd_en), 32'd0);
    checkOutput("reset_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp", 32'({rsp_hit, rsp_oob, rsp_owner}), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    @(negedge CLOCK_50);
    reset = 1'b0;

    $display("[TB] empty cell");
    applyStimulus(216, 240, 1'b0);
    waitResponse(0);

    $display("[TB] single owner, coordinates change after accept");
    mem[156380] = 8'h01;
    applyStimulus(216, 240, 1'b0);
    req_x = 10'd8;
    req_y = 10'd8;
    waitResponse(0);
    repeat (5) @(posedge CLOCK_50);
    #1;
    checkOutput("hit_held", 32'(rsp_hit), 32'd1);
    checkOutput("owner_held", 32'(rsp_owner), 32'h01);

    $display("[TB] first owner wins");
    mem.delete();
    mem[153817] = 8'h02;
    mem[158300] = 8'h01;
    applyStimulus(216, 240, 1'b0);
    waitResponse(0);

    $display("[TB] arena edges");
    mem.delete();
    applyStimulus(616, 456, 1'b0);
    waitResponse(0);
    applyStimulus(617, 240, 1'b0);
    waitResponse(0);
    repeat (3) @(posedge CLOCK_50);
    #1;
    checkOutput("oob_held", 32'(rsp_oob), 32'd1);
    applyStimulus(8, 8, 1'b0);
    waitResponse(0);
    applyStimulus(16, 16, 1'b0);
    waitResponse(0);
    applyStimulus(16, 457, 1'b0);
    waitResponse(0);
    applyStimulus(15, 100, 1'b0);
    waitResponse(0);

    $display("[TB] reset during scan");
    applyStimulus(216, 240, 1'b0);
    repeat (30) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(posedge CLOCK_50);
    #1;
    checkOutput("abort_rd_en", 32'(rd_en), 32'd0);
    checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
    checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("abort_reads_done", 32'(BLK - addr_q.size()), 32'd30);
    @(negedge CLOCK_50);
    reset = 1'b0;
    addr_q.delete();
    rsp_q.delete();
    got = 1'b0;
    repeat (80) begin
      @(posedge CLOCK_50);
      #1;
      if (rsp_valid) got = 1'b1;
    end
    checkOutput("no_rsp_after_abort", 32'(got), 32'd0);
    applyStimulus(216, 240, 1'b0);
    waitResponse(0);

    $display("[TB] held request with stray read data");
    stray_val = 8'hA5;
    repeat (4) @(posedge CLOCK_50);
    applyStimulus(216, 240, 1'b1);
    waitResponse(0);
    pushExpect(216, 240);
    checkOutput("req_ready_after_done", 32'(req_ready), 32'd1);
    @(posedge CLOCK_50);
    #1;
    req_valid = 1'b0;
    checkOutput("second_accept", 32'(req_ready), 32'd0);
    waitResponse(0);
    stray_val = 8'h00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
